// File: rtl/arb8way16.sv
// arb8way16: round-robin arbiter/sequencer in front of a shared 8-way 16-bit word mux.
// Define ARB8WAY16_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module arb8way16 #(
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] in_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_sel,
  output logic [7:0]          grant,
  output logic                busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] search_start;
  logic [3:0] pick;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic       xfer;
  logic       burst_end;
  logic       grant_end;

  // Returns {found, index} of the first asserted request at or after start, wrapping mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = start + 3'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

`ifdef ARB8WAY16_FIXED_PRIO_EN
  assign search_start = 3'd0;
`else
  logic [2:0] last_q, last_d;

  assign search_start = last_q + 3'd1;
`endif

  assign pick       = rr_pick(req, search_start);
  assign pick_found = pick[3];
  assign pick_idx   = pick[2:0];

  // Output side is combinational off the registered select so a grant is usable the cycle it appears.
  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign out_data  = in_data[sel_q*DATA_W +: DATA_W];
  assign out_sel   = sel_q;
  assign grant     = grant_q;
  assign busy      = (state_q == GRANT);

  assign xfer      = out_valid && out_ready;
  assign burst_end = xfer && (cnt_q == 4'(MAX_BURST - 1));
  assign grant_end = burst_end || !req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
`ifndef ARB8WAY16_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = 8'b1 << pick_idx;
          cnt_d   = 4'd0;
`ifndef ARB8WAY16_FIXED_PRIO_EN
          last_d  = pick_idx;
`endif
        end
      end
      GRANT: begin
        // At end of grant the next holder is loaded directly, so there is no idle bubble.
        if (grant_end) begin
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = 8'b1 << pick_idx;
            cnt_d   = 4'd0;
`ifndef ARB8WAY16_FIXED_PRIO_EN
            last_d  = pick_idx;
`endif
          end else begin
            state_d = IDLE;
            grant_d = 8'd0;
            cnt_d   = 4'd0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      grant_q <= 8'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef ARB8WAY16_FIXED_PRIO_EN
  // Reset to 7 so the first search after reset begins at requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 3'd7;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule
